pn_lfsr_engine: RTL
===================

# pn_lfsr_engine

Parametrised, runtime-configurable PN sequence engine that replaces the fixed-length PN generator in the display path. A single instance supports any register length from 2 to W, Fibonacci or Galois form, a caller-supplied tap mask, and either single-step or free-run advance. It also measures the sequence period and flags degenerate configurations. It sits between the debounced button / polynomial-ROM logic and the BCD/seven-segment display chain.

## Interface
- W, 16, maximum LFSR width (≥ 4)
- LEN_W, 5, width of the len port (must hold W)
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- load  in  1  one-cycle pulse; captures seed, taps, len, mode
- seed  in  W  initial state (bits ≥ len ignored)
- taps  in  W  feedback tap mask (bits ≥ len ignored)
- len  in  LEN_W  active register length, legal 2..W
- mode  in  1  0 = Fibonacci, 1 = Galois
- step  in  1  advance one state (pulse, already debounced)
- run  in  1  level; advance every cycle while high
- state_out  out  W  current state, bits ≥ len always 0
- bit_out  out  1  output bit: Fibonacci state[len-1], Galois state[0]
- valid  out  1  state_out holds a legal sequence value
- wrap  out  1  one-cycle pulse: state just returned to seed
- period  out  W  advances between the last two seed visits
- error  out  1  sticky configuration/lock-up fault

## Operation
- mask = (1<<len)-1; the registered seed, taps, len and mode (cfg) are used after load.
- FSM states:
  - IDLE: reset state.
  - ARMED: sequencing.
  - ERR: fault.
- Any state + load:
  - If the config is illegal (len<2, len>W, seed&mask==0, taps&mask==0): → ERR, error=1, valid=0.
  - Otherwise: → ARMED, state=seed&mask, cnt=0, error=0, valid=1.
- ARMED: adv = step | run. When both are high, exactly one advance occurs.
- Fibonacci: fb = ^(state & taps & mask); next = ((state<<1) | fb) & mask.
- Galois: next = ((state>>1) ^ ({W{state[0]}} & taps)) & mask.
- On each advance:
  - If next == 0: → ERR, error=1, valid=0, state_out keeps its last value.
  - Else if next == seed&mask: wrap=1, period=cnt+1, cnt=0.
  - Else: cnt=cnt+1, saturating at all-ones with no wrap.
- load has priority over adv in the same cycle; no advance happens on a load cycle.
- IDLE and ERR ignore step and run; only load or rst leaves them.
- period holds its value until the next wrap or load. A load clears it to 0.

## Timing
- Reset values:
  - FSM = IDLE.
  - state_out = 0, bit_out = 0, valid = 0, wrap = 0, period = 0, error = 0.
  - cnt = 0, all cfg registers = 0.
- rst deassertion is synchronised internally with a 2-flop release; rst assertion takes effect immediately, including mid-run.
- load sampled at edge k → state_out/valid/error updated at edge k, visible in cycle k+1.
- Advance sampled at edge k → new state_out at edge k. Any wrap/period/error from that advance is updated on the same edge.
- Throughput: one state per cycle with run=1.
- All outputs are registered, except bit_out, which is a mux of registered state_out by cfg mode/len.

## Structure
- Package pn_pkg holds:
  - the FSM state enum (IDLE, ARMED, ERR);
  - the mode constants MODE_FIB = 1'b0 and MODE_GAL = 1'b1;
  - the function build_mask(len).
- Sub-module lfsr_next_state: purely combinational (state, taps, len, mode) → next. It is reused by the verification model.
- The top-level module holds the FSM, cfg registers, period counter and reset synchroniser.

## Test plan
- Fibonacci, W=16, len=4, taps=0x9, seed=0x1, load then 15 single steps → state_out 0x3, 0x7, 0xF, 0xE, … 0x8, 0x1. wrap pulses only on the 15th step, period=15, valid=1 throughout.
- Galois, len=4, taps=0xC, seed=0x1, run=1 for 15 cycles → 0xC, 0x6, 0x3, 0xD, … 0x2, 0x1. wrap on cycle 15, period=15. bit_out equals state_out[0] each cycle.
- Illegal loads → error=1, valid=0, FSM in ERR, step ignored:
  - len=1;
  - seed=0x0 with len=4;
  - taps=0x10 with len=4 (masked to zero).
  A following legal load clears error.
- Lock-up: Fibonacci, len=4, taps=0x1, seed=0x8, one step → next=0, so ERR, error=1, state_out stays 0x8.
- Priority and simultaneous events:
  - load+step in the same cycle → state=seed, cnt=0, no advance.
  - step+run for 3 cycles → exactly 3 advances.
  - Fibonacci len=16 taps=0xD008 free-run → seed not revisited in 1000 cycles; period unchanged at 0.
- Reset mid-run: assert rst while ARMED → all outputs read 0 within the same cycle. After rst release, step is ignored until a load.

Source files
------------

// File: rtl/pn_pkg.sv
// Shared types and helpers for the PN sequence engine.
package pn_pkg;

  localparam int unsigned PN_MAX_W = 32;
  localparam int unsigned PN_LEN_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ERR   = 2'd2
  } pn_fsm_e;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

  // Low 'len' bits set; len beyond PN_MAX_W saturates to all ones.
  function automatic logic [PN_MAX_W-1:0] build_mask(input logic [PN_LEN_W-1:0] len);
    logic [PN_MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < PN_MAX_W; i++) begin
      m[i] = (i < 32'(len));
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr_next_state.sv
// Combinational one-step LFSR advance in Fibonacci or Galois form over 'len' active bits.
module lfsr_next_state
  import pn_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned LEN_W = 5
) (
  input  logic [W-1:0]     state,
  input  logic [W-1:0]     taps,
  input  logic [LEN_W-1:0] len,
  input  logic             mode,
  output logic [W-1:0]     next_c
);

  logic [W-1:0] mask;
  logic         fb;

  always_comb begin
    mask = W'(build_mask(PN_LEN_W'(len)));
    fb   = ^(state & taps & mask);
    if (mode == MODE_GAL) begin
      next_c = ((state >> 1) ^ ({W{state[0]}} & taps)) & mask;
    end else begin
      next_c = {state[W-2:0], fb} & mask;
    end
  end

endmodule

// File: rtl/pn_lfsr_engine.sv
// Runtime-configurable PN engine: config capture, sequencing FSM, period measurement, fault flagging.
module pn_lfsr_engine
  import pn_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W-1:0]     seed,
  input  logic [W-1:0]     taps,
  input  logic [LEN_W-1:0] len,
  input  logic             mode,
  input  logic             step,
  input  logic             run,
  output logic [W-1:0]     state_out,
  output logic             bit_out,
  output logic             valid,
  output logic             wrap,
  output logic [W-1:0]     period,
  output logic             error
);

  // Reset asserts immediately, releases two clocks later.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  pn_fsm_e          fsm_q, fsm_d;
  logic [W-1:0]     cfg_seed, cfg_seed_d;
  logic [W-1:0]     cfg_taps, cfg_taps_d;
  logic [LEN_W-1:0] cfg_len, cfg_len_d;
  logic             cfg_mode, cfg_mode_d;
  logic [W-1:0]     cnt_q, cnt_d;
  logic [W-1:0]     state_d, period_d;
  logic             valid_d, wrap_d, error_d;

  logic [W-1:0]     load_mask_c;
  logic [W-1:0]     cfg_mask_c;
  logic             load_legal_c;
  logic [W-1:0]     next_c;
  logic             fib_bit_c;

  lfsr_next_state #(
    .W     (W),
    .LEN_W (LEN_W)
  ) u_next (
    .state  (state_out),
    .taps   (cfg_taps),
    .len    (cfg_len),
    .mode   (cfg_mode),
    .next_c (next_c)
  );

  always_comb begin
    load_mask_c  = W'(build_mask(PN_LEN_W'(len)));
    cfg_mask_c   = W'(build_mask(PN_LEN_W'(cfg_len)));
    load_legal_c = (len >= LEN_W'(2)) && (len <= LEN_W'(W)) &&
                   ((seed & load_mask_c) != '0) && ((taps & load_mask_c) != '0);
  end

  // Next-state and registered-output logic; load outranks any advance.
  always_comb begin
    fsm_d      = fsm_q;
    cfg_seed_d = cfg_seed;
    cfg_taps_d = cfg_taps;
    cfg_len_d  = cfg_len;
    cfg_mode_d = cfg_mode;
    cnt_d      = cnt_q;
    state_d    = state_out;
    period_d   = period;
    valid_d    = valid;
    wrap_d     = 1'b0;
    error_d    = error;

    if (load) begin
      cfg_seed_d = seed;
      cfg_taps_d = taps;
      cfg_len_d  = len;
      cfg_mode_d = mode;
      cnt_d      = '0;
      period_d   = '0;
      if (load_legal_c) begin
        fsm_d   = ARMED;
        state_d = seed & load_mask_c;
        valid_d = 1'b1;
        error_d = 1'b0;
      end else begin
        fsm_d   = ERR;
        state_d = '0;
        valid_d = 1'b0;
        error_d = 1'b1;
      end
    end else if ((fsm_q == ARMED) && (step || run)) begin
      if (next_c == '0) begin
        fsm_d   = ERR;
        valid_d = 1'b0;
        error_d = 1'b1;
      end else begin
        state_d = next_c;
        if (next_c == (cfg_seed & cfg_mask_c)) begin
          wrap_d   = 1'b1;
          period_d = cnt_q + W'(1);
          cnt_d    = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      cfg_seed  <= '0;
      cfg_taps  <= '0;
      cfg_len   <= '0;
      cfg_mode  <= MODE_FIB;
      cnt_q     <= '0;
      state_out <= '0;
      period    <= '0;
      valid     <= 1'b0;
      wrap      <= 1'b0;
      error     <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      cfg_seed  <= cfg_seed_d;
      cfg_taps  <= cfg_taps_d;
      cfg_len   <= cfg_len_d;
      cfg_mode  <= cfg_mode_d;
      cnt_q     <= cnt_d;
      state_out <= state_d;
      period    <= period_d;
      valid     <= valid_d;
      wrap      <= wrap_d;
      error     <= error_d;
    end
  end

  // Output bit taps the top active stage (Fibonacci) or stage 0 (Galois).
  always_comb begin
    fib_bit_c = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (LEN_W'(i + 1) == cfg_len) fib_bit_c = state_out[i];
    end
    bit_out = (cfg_mode == MODE_FIB) ? fib_bit_c : state_out[0];
  end

endmodule
